// File: rtl/ascon_inv_substitution.sv
// Iterative inverse of the Ascon round front half: inverse S-box over the 320-bit
// state, COLS_PER_CYCLE columns per clock, then removal of the round constant.
package ascon_pkg;
  typedef logic [4:0][63:0] t_state_array;  // word 0 is x0

  localparam logic [7:0] LUT_ADDITION [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  localparam logic [4:0] LUT_SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };
endpackage

module ascon_inv_substitution
  import ascon_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_start,
  input  logic [3:0]   i_round,
  input  t_state_array i_state,
  output t_state_array o_state,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

  // A full-width step of 64 truncates to 0, so the counter simply stays at 0.
  localparam logic [5:0] COL_STEP = 6'(COLS_PER_CYCLE);
  localparam logic [5:0] LAST_CNT = 6'(64 - COLS_PER_CYCLE);

  function automatic bit sbox_pair_ok();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 32; k++)
      if (INV_SBOX[LUT_SBOX[k]] != 5'(k)) ok = 1'b0;
    return ok;
  endfunction

  if (!((COLS_PER_CYCLE == 1)  || (COLS_PER_CYCLE == 2)  || (COLS_PER_CYCLE == 4) ||
        (COLS_PER_CYCLE == 8)  || (COLS_PER_CYCLE == 16) || (COLS_PER_CYCLE == 32) ||
        (COLS_PER_CYCLE == 64))) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
  end

  if (!sbox_pair_ok()) begin : g_bad_sbox
    $error("INV_SBOX is not the inverse of LUT_SBOX");
  end

  function automatic t_state_array subst_cols(t_state_array s, logic [5:0] base);
    t_state_array r;
    logic [5:0]   j;
    logic [4:0]   v;
    r = s;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      j = base + 6'(i);
      v = INV_SBOX[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
      r[0][j] = v[4];
      r[1][j] = v[3];
      r[2][j] = v[2];
      r[3][j] = v[1];
      r[4][j] = v[0];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, SUBST, CONST, DONE} t_fsm;

  t_fsm         state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [3:0]   round_q, round_d;
  t_state_array work_q, work_d;
  t_state_array o_state_q, o_state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    work_d    = work_q;
    o_state_d = o_state_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          work_d  = i_state;
          round_d = i_round;
          cnt_d   = '0;
          state_d = SUBST;
        end
      end
      SUBST: begin
        work_d = subst_cols(work_q, cnt_q);
        cnt_d  = cnt_q + COL_STEP;
        if (cnt_q == LAST_CNT) state_d = CONST;
      end
      CONST: begin
        o_state_d = work_q;
        if (round_q < 4'd12)
          o_state_d[2][7:0] = work_q[2][7:0] ^ LUT_ADDITION[round_q];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SUBST) || (state_d == CONST);
    // The done flag is registered out of DONE, giving 64/COLS_PER_CYCLE + 2 cycles of latency.
    done_d = (state_q == DONE);
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the working register is reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      work_q    <= '0;
      o_state_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      work_q    <= work_d;
      o_state_q <= o_state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_state = o_state_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
